// File: rtl/conversor_bcd_sequencial_pkg.sv
// Shared constants for the binary-to-BCD output path: the blanking pattern
// the 7-segment decoders recognise, default geometry, and the FSM encoding.
package conversor_bcd_sequencial_pkg;

  // Digit pattern the downstream decoders turn into a dark segment.
  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Default geometry: 32-bit binary in, 10 decimal digits out, 4 shown.
  localparam int DEF_WIDTH       = 32;
  localparam int DEF_DIGITS      = 10;
  localparam int DEF_DISP_DIGITS = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/conversor_bcd_sequencial_ajuste3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so
// the following left shift carries correctly into the next decimal digit.
module bcd_ajuste3 (
  input  logic [3:0] digitIn,
  output logic [3:0] digitOut
);

  // Digits 5..9 map to 8..12; the 4-bit add never needs a carry out.
  assign digitOut = (digitIn >= 4'd5) ? digitIn + 4'd3 : digitIn;

endmodule

// File: rtl/conversor_bcd_sequencial.sv
// Multi-cycle binary-to-BCD converter (shift-and-add-3). One shift per clock,
// WIDTH clocks per conversion, start/busy/done handshake. Results are only
// published on completion and held until the next conversion finishes.
module conversor_bcd_sequencial
  import conversor_bcd_sequencial_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DIGITS      = DEF_DIGITS,
  parameter int DISP_DIGITS = DEF_DISP_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  overflow
);

  localparam int             CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t                state;
  logic [WIDTH-1:0]      shiftReg;
  logic [4*DIGITS-1:0]   scratch;
  logic [CW-1:0]         count;

  logic [4*DIGITS-1:0]   adjusted;
  logic [4*DIGITS-1:0]   nextScratch;
  logic [WIDTH-1:0]      nextShift;
  logic [DIGITS-1:0]     nextValid;
  logic                  nextOverflow;
  logic                  anyAbove;

  // One correction cell per scratch digit; digits are adjusted independently.
  for (genvar g = 0; g < DIGITS; g++) begin : g_ajuste
    bcd_ajuste3 u_ajuste (
      .digitIn  (scratch[4*g +: 4]),
      .digitOut (adjusted[4*g +: 4])
    );
  end

  // Adjusted scratch and binary shift register move left together as one word.
  assign {nextScratch, nextShift} = {adjusted, shiftReg} << 1;

  // Leading-zero scan and overflow detect on the scratch value after this shift.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so no
    // path leaves it unassigned and no latch is inferred.
    nextValid    = '0;
    nextOverflow = 1'b0;
    anyAbove     = 1'b0;
    // NOTE: blocking assignments here are deliberate: anyAbove is a running OR
    // from the top digit down, each iteration must see the previous result.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      anyAbove     = anyAbove | (|nextScratch[4*i +: 4]);
      nextValid[i] = anyAbove;
      if (i >= DISP_DIGITS) begin
        nextOverflow = nextOverflow | (|nextScratch[4*i +: 4]);
      end
    end
    // Units digit is always shown, even for a zero result.
    nextValid[0] = 1'b1;
  end

  // Conversion FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      shiftReg    <= '0;
      scratch     <= '0;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd_out     <= '0;
      digit_valid <= DIGITS'(1);
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shiftReg <= bin_in;
            scratch  <= '0;
            count    <= '0;
            busy     <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          scratch  <= nextScratch;
          shiftReg <= nextShift;
          count    <= count + CW'(1);
          // This edge performs the final shift: publish the result.
          if (count == LAST) begin
            bcd_out     <= nextScratch;
            digit_valid <= nextValid;
            overflow    <= nextOverflow;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd_sequencial.sv
// Self-checking bench for conversor_bcd_sequencial: directed handshake and
// reset scenarios plus randomized conversions against a decimal reference.
module tb_conversor_bcd_sequencial;

  localparam int WIDTH  = 32;
  localparam int DIGITS = 10;
  localparam int DISP   = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start;
  logic [WIDTH-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic [DIGITS-1:0]   digit_valid;
  logic                overflow;

  int checks = 0;
  int errors = 0;
  int doneSeen = 0;
  int doneExp  = 0;

  logic [4*DIGITS-1:0] heldBcd;
  logic [DIGITS-1:0]   heldValid;
  logic                heldOvf;
  logic [WIDTH-1:0]    curVal;

  conversor_bcd_sequencial #(
    .WIDTH       (WIDTH),
    .DIGITS      (DIGITS),
    .DISP_DIGITS (DISP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .bin_in      (bin_in),
    .busy        (busy),
    .done        (done),
    .bcd_out     (bcd_out),
    .digit_valid (digit_valid),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  // Count every done pulse, sampled away from the active edge.
  always @(negedge clk) if (done === 1'b1) doneSeen++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: decimal digits by repeated division.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input logic [WIDTH-1:0] v);
    longint unsigned x = 64'(v);
    logic [4*DIGITS-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] ref_valid(input logic [WIDTH-1:0] v);
    longint unsigned x = 64'(v);
    int n = 1;
    while (x >= 10) begin
      x = x / 10;
      n++;
    end
    return DIGITS'((1 << n) - 1);
  endfunction

  function automatic logic ref_ovf(input logic [WIDTH-1:0] v);
    longint unsigned lim = 1;
    for (int i = 0; i < DISP; i++) lim = lim * 10;
    return 64'(v) >= lim;
  endfunction

  // Present a value at a negedge; returns at the negedge after the accepting edge.
  task automatic start_conv(input logic [WIDTH-1:0] v);
    start  = 1'b1;
    bin_in = v;
    curVal = v;
    @(negedge clk);
    start  = 1'b0;
    bin_in = $urandom;
    check("busy_after_accept", 64'(busy), 64'(1));
    check("done_low_after_accept", 64'(done), 64'(0));
  endtask

  // Wait for done (bounded), optionally pulsing a start that must be ignored.
  task automatic wait_done(input int ignoreAt, input logic [WIDTH-1:0] ignoreVal);
    int lat = 0;
    int busyHigh = 1;
    bit seen = 0;
    bit heldOk = 1;
    while (!seen && lat < 100) begin
      if (ignoreAt != 0 && lat == ignoreAt) begin
        start  = 1'b1;
        bin_in = ignoreVal;
      end
      @(negedge clk);
      lat++;
      if (start) begin
        start  = 1'b0;
        bin_in = $urandom;
      end
      if (done === 1'b1) seen = 1;
      else begin
        if (busy === 1'b1) busyHigh++;
        if (bcd_out !== heldBcd || digit_valid !== heldValid || overflow !== heldOvf) heldOk = 0;
      end
    end
    check("done_seen", 64'(seen), 64'(1));
    check("latency", 64'(lat), 64'(WIDTH));
    check("busy_cycles", 64'(busyHigh), 64'(WIDTH));
    check("outputs_held", 64'(heldOk), 64'(1));
    check("busy_low_at_done", 64'(busy), 64'(0));
    check("bcd_out", 64'(bcd_out), 64'(ref_bcd(curVal)));
    check("digit_valid", 64'(digit_valid), 64'(ref_valid(curVal)));
    check("overflow", 64'(overflow), 64'(ref_ovf(curVal)));
    heldBcd   = ref_bcd(curVal);
    heldValid = ref_valid(curVal);
    heldOvf   = ref_ovf(curVal);
    doneExp++;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_bcd"}, 64'(bcd_out), 64'(0));
    check({tag, "_valid"}, 64'(digit_valid), 64'(1));
    check({tag, "_ovf"}, 64'(overflow), 64'(0));
  endtask

  // One idle cycle after done: pulse must be gone and results still held.
  task automatic idle_cycle();
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'(0));
    check("idle_hold_bcd", 64'(bcd_out), 64'(heldBcd));
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    bit stray;
    reset_n   = 1'b1;
    start     = 1'b0;
    bin_in    = '0;
    heldBcd   = '0;
    heldValid = DIGITS'(1);
    heldOvf   = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Zero, a small value and the all-ones boundary.
    start_conv(32'd0);          wait_done(0, '0); idle_cycle();
    start_conv(32'd1234);       wait_done(0, '0); idle_cycle();
    start_conv(32'hFFFF_FFFF);  wait_done(0, '0);
    check("max_bcd_literal", 64'(bcd_out), 64'h4294967295);
    idle_cycle();

    // Start while busy is ignored; start during done is accepted.
    start_conv(32'd9999);
    wait_done(10, 32'd55);
    check("ignored_start_bcd", 64'(bcd_out), 64'h9999);
    start_conv(32'd10000);
    wait_done(0, '0);
    check("b2b_bcd_literal", 64'(bcd_out), 64'h0000010000);
    check("b2b_ovf", 64'(overflow), 64'(1));
    idle_cycle();

    // Reset in the middle of a conversion aborts it without a done.
    start_conv(32'd77); wait_done(0, '0); idle_cycle();
    start_conv(32'd500);
    repeat (14) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    heldBcd   = '0;
    heldValid = DIGITS'(1);
    heldOvf   = 1'b0;
    stray = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) stray = 1;
    end
    check("no_done_after_abort", 64'(stray), 64'(0));
    check_reset_values("after_abort");
    start_conv(32'd42); wait_done(0, '0);
    check("after_abort_bcd", 64'(bcd_out), 64'h0042);
    idle_cycle();

    // Randomized conversions, sometimes back-to-back in the done cycle.
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9999);
        1:       v = $urandom_range(0, 99);
        default: v = $urandom;
      endcase
      start_conv(v);
      wait_done(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0, $urandom);
      if ($urandom_range(0, 1) == 0) idle_cycle();
    end
    repeat (3) @(negedge clk);
    check("done_pulse_count", 64'(doneSeen), 64'(doneExp));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so a stuck DUT cannot hang the run.
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion expected finish before %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
